// File: rtl/uart_tx_ser_if.sv
// Word handshake between a producer and the uart_tx_ser transmitter.
// The master drives the data word and valid; the transmitter answers with ready.
interface uart_tx_ser_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_tx_ser.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_ser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          br_i,
    uart_tx_ser_if.slave  bus,
    output logic          start_o,
    output logic          tx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        idle_st, start_br_st, start_st, data_st, parity_st, stop_st
    } state_t;
`else
    typedef enum logic [2:0] {
        idle_st, start_br_st, start_st, data_st, stop_st
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  load;
    logic                  accept;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    assign accept      = bus.valid_i & ~hold_full_q;
    assign bus.ready_o = ~hold_full_q;
    // Shift register and counter are (re)loaded on every entry to start_br_st.
    assign load        = (state_d == start_br_st);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= idle_st;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            if (load) begin
                hold_full_q <= 1'b0;
            end else if (accept) begin
                hold_q      <= bus.data_i;
                hold_full_q <= 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^hold_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            idle_st: begin
                if (hold_full_q) state_d = start_br_st;
            end
            start_br_st: begin
                state_d = start_st;
            end
            start_st: begin
                if (br_i) state_d = data_st;
            end
            data_st: begin
                if (br_i) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = parity_st;
`else
                        state_d = stop_st;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            parity_st: begin
                if (br_i) state_d = stop_st;
            end
`endif
            stop_st: begin
                if (br_i) state_d = hold_full_q ? start_br_st : idle_st;
            end
            default: begin
                state_d = idle_st;
            end
        endcase
        if (load) begin
            shift_d = hold_q;
            cnt_d   = '0;
        end
    end

    // The line level is registered from the upcoming state so tx_o changes with the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            start_st:  tx_d = 1'b0;
            data_st:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            parity_st: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx_o    = tx_q;
    assign start_o = (state_q == start_br_st);
    assign busy_o  = (state_q != idle_st);
    assign done_o  = (state_q == stop_st) & br_i;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Randomized scoreboard bench for uart_tx_ser with a 16-clock external baud counter.
module tb_uart_tx_ser;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_N = 11;
`else
    localparam int FRAME_N = 10;
`endif
    localparam int BIT_CLKS = 16;

    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          b2b;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic br;
    logic start, tx, busy, done;
    int   bcnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    frame_t exp_q[$];
    frame_t cur;
    bit     in_frame = 0;
    bit     busy_chk = 0;
    int     k = 0;
    int     last_done = -100;

    uart_tx_ser_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ser #(.DATA_WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .br_i    (br),
        .bus     (bus),
        .start_o (start),
        .tx_o    (tx),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    // External baud counter: restarted by start_o, ticks once per 16 clocks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || start) bcnt <= 0;
        else bcnt <= (bcnt == BIT_CLKS - 1) ? 0 : bcnt + 1;
    end
    assign br = (bcnt == BIT_CLKS - 1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input bit b2b);
        frame_t f;
        f.bits = '0;
        f.n    = FRAME_N;
        f.b2b  = b2b;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        f.bits[9] = ^d;
`endif
        f.bits[FRAME_N - 1] = 1'b1;
        return f;
    endfunction

    // Monitor: frames are sampled mid-bit, relative to the observed start_o pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                busy_chk = 0;
            end else begin
                if (busy_chk) begin
                    busy_chk = 0;
                    chk("busy_after_done", busy, 0);
                end
                if (in_frame) begin
                    k++;
                    if ((k % BIT_CLKS) == BIT_CLKS / 2 && (k / BIT_CLKS) < cur.n)
                        chk($sformatf("frame_bit%0d", k / BIT_CLKS), tx, cur.bits[k / BIT_CLKS]);
                    if (k == BIT_CLKS * cur.n) begin
                        chk("done_pulse", done, 1);
                        in_frame  = 0;
                        last_done = cyc;
                        if (exp_q.size() > 0 && exp_q[0].b2b) chk("ready_while_held", bus.ready_o, 0);
                        else busy_chk = 1;
                    end else if (done) begin
                        chk("spurious_done", done, 0);
                    end
                end else begin
                    if (done) chk("spurious_done", done, 0);
                    if (start) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_start: got start_o=1 expected no frame (cycle %0d)", cyc);
                        end else begin
                            cur      = exp_q.pop_front();
                            in_frame = 1;
                            k        = 0;
                            chk("line_high_at_start", tx, 1);
                            chk("ready_at_start", bus.ready_o, 1);
                            if (cur.b2b) chk("b2b_gap", cyc - last_done, 1);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int t = 0;
        while (!bus.ready_o && t < 2000) begin
            tick();
            t++;
        end
        if (!bus.ready_o) begin
            chk("ready_timeout", bus.ready_o, 1);
        end else begin
            bus.data_i  = d;
            bus.valid_i = 1'b1;
            exp_q.push_back(make_frame(d, busy && !done));
            tick();
            bus.valid_i = 1'b0;
            chk("ready_after_accept", bus.ready_o, 0);
        end
    endtask

    // Offer a word only while the holding register is full; it must be dropped.
    task automatic offer_dropped(input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            bus.data_i  = d;
            bus.valid_i = !bus.ready_o;
            tick();
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || in_frame || busy) && t < 5000) begin
            tick();
            t++;
        end
        chk("drain_timeout", (exp_q.size() != 0 || in_frame || busy), 0);
    endtask

    task automatic wait_start();
        int t = 0;
        while (!start && t < 500) begin
            tick();
            t++;
        end
        chk("start_timeout", start, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tx"}, tx, 1);
        chk({tag, "_ready"}, bus.ready_o, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [7:0] d;
        int mode;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;

        repeat (3) tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("post_reset");

        send(8'hA5);
        wait_idle();
        send(8'h07);
        wait_idle();

        // Back-to-back with a dropped word while the hold register is occupied.
        send(8'h3C);
        wait_start();
        send(8'hFF);
        offer_dropped(8'h11);
        wait_idle();

        // Asynchronous reset in the middle of data bit 4.
        send(8'h55);
        wait_start();
        repeat (BIT_CLKS * 5 + BIT_CLKS / 2) tick();
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        send(8'hC3);
        wait_idle();

        for (int i = 0; i < 14; i++) begin
            d    = 8'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 1) repeat ($urandom_range(0, 60)) tick();
            if (mode == 2) wait_idle();
            send(d);
            if (mode == 3) offer_dropped(8'($urandom));
        end
        wait_idle();
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
- UART transmitter: serializes one parallel word into an 8N1-style frame on tx_o. Order is start bit (0), data LSB first, optional parity bit, stop bit (1).
- Pairs with the existing UART receiver and shares the same external baud counter handshake. start_o restarts the counter; br_i is the bit-period tick.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- DATA_WIDTH, 8, data bits per frame (legal range 5..9).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- br_i  input  1  one-cycle baud tick; first tick arrives one bit period after start_o.
- data_i  input  DATA_WIDTH  word to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  holding register empty; word accepted when valid_i & ready_o.
- start_o  output  1  one-cycle pulse that restarts the baud counter at frame start.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  frame in progress (state != idle_st).
- done_o  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-frame:
  - state = idle_st, tx_o = 1, ready_o = 1.
  - start_o, busy_o, done_o = 0.
  - Holding register and shift register cleared; bit counter = 0.
- Holding register:
  - valid_i & ready_o loads data_i into hold and sets hold_full on the next edge.
  - ready_o = !hold_full. valid_i while ready_o = 0 is ignored (word not accepted).
  - hold_full clears on the edge the FSM enters start_br_st. No same-cycle fill and drain is possible.
- FSM states: idle_st, start_br_st, start_st, data_st, parity_st (only if PARITY_EN), stop_st. Transitions:
  - idle_st -> start_br_st when hold_full.
  - start_br_st -> start_st unconditionally, after one cycle. start_o = 1 only in this state. Shift register loaded from hold; bit counter = 0. br_i ignored here.
  - start_st -> data_st on br_i.
  - data_st on br_i:
    - Shift right and increment the counter.
    - When counter == DATA_WIDTH-1, go to parity_st (or stop_st without PARITY_EN).
  - parity_st -> stop_st on br_i.
  - stop_st on br_i: done_o = 1 for that cycle. Next state is start_br_st if hold_full, else idle_st. The back-to-back case inserts exactly one clock of stop-level line before the next start_o cycle.
  - Illegal or default state -> idle_st.
- tx_o:
  - Registered; it takes the level of the next state on the same edge the state updates.
  - Levels by state: idle_st = 1, start_br_st = 1, start_st = 0, data_st = shift[0], parity_st = parity, stop_st = 1.
- Latency: valid_i accepted at edge N -> hold_full at N+1 -> start_br_st at N+2 -> tx_o falls at N+3.
- A word loaded during a frame waits in hold. ready_o stays 0 until that word is moved to the shift register.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - parity_st is compiled in.
  - Parity bit = XOR of all data bits (even parity), computed when the shift register is loaded.
  - Frame length = DATA_WIDTH + 3 bit periods.
- Undefined:
  - No parity_st and no parity logic.
  - Frame length = DATA_WIDTH + 2 bit periods.

Test Plan:
All scenarios use DATA_WIDTH = 8 and br_i every 16 clocks.
- Reset: hold rst_ni = 0 for 3 cycles -> tx_o = 1, ready_o = 1, busy_o = 0, no start_o. Release -> outputs unchanged with valid_i = 0.
- Single frame: send 0xA5 -> start_o one pulse; tx_o bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). done_o one pulse after the stop tick; busy_o falls next cycle.
- Back-to-back: send 0x3C, then send 0xFF while ready_o = 1 during the 0x3C frame.
  - ready_o is 0 until the 0xFF word moves to the shift register.
  - After the first stop tick: exactly one stop-level clock, then start_o, then 0xFF's frame.
- Backpressure: assert valid_i with 0x11 while hold is full -> word dropped; only the previously held word is transmitted.
- Reset mid-frame: drive rst_ni = 0 during data bit 4 of 0x55 -> tx_o = 1 asynchronously; no done_o; next word sends a clean full frame.
- Parity (UART_TX_PARITY_EN defined):
  - 0xA5 -> parity bit 0.
  - 0x07 -> parity bit 1.
  - Frames are 11 bit periods; done_o only after the stop bit.
